id_hazard_ctrl: RTL
===================

Name: id_hazard_ctrl

Overview:
Hazard and sequencing controller for the decode stage. It generates the decode-stage stall and the two operand-forwarding selects from the EXE/MEM/WB destination registers. It also owns a multi-cycle divider sequencer that locks out HI/LO users in decode until the divide result is written. It sits between the decode stage, the EXE/MEM/WB pipeline registers and the HI/LO register pair.

Parameters:
DIV_LAT, 8, total divider cycles from issue to HI/LO write (legal 2..31).
CNT_W, 32, width of the optional stall counters.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
ID_src1  in  5  decode source register 1 (0 = unused).
ID_src2  in  5  decode source register 2 (0 = unused).
ID_hilo_use  in  1  decode instruction is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU.
EXE_dest  in  5  EXE destination (0 = none).
EXE_memtoreg  in  1  EXE instruction is a load.
MEM_dest  in  5  MEM destination.
WB_dest  in  5  WB destination.
EXE_div_issue  in  1  one-cycle pulse: DIV/DIVU entered EXE this cycle.
ID_stall  out  1  hold decode, inject bubble into EXE.
ID_vsrc1_for  out  2  00 regfile, 01 EXE, 10 MEM, 11 WB.
ID_vsrc2_for  out  2  00 regfile, 10 MEM, 11 WB (01 never driven).
div_busy  out  1  divider sequencer not IDLE.
div_cnt  out  5  remaining divider cycles.
hilo_div_we  out  1  one-cycle HI/LO write strobe for the divide result.
stall_ld_cnt  out  CNT_W  load-use/EXE-conflict stall cycles.
stall_div_cnt  out  CNT_W  divider lock-out stall cycles.

Behaviour:
- Reset (resetn=0, asynchronous): FSM=IDLE, div_cnt=0, hilo_div_we=0, counters=0. With all dests 0 after reset: ID_stall=0, both forward selects=00.
- Forwarding is combinational, with priority EXE > MEM > WB. A source equal to 0 never matches and never stalls.
- src1: EXE match with EXE_memtoreg=0 gives 01. EXE match with EXE_memtoreg=1 raises load-use stall. Otherwise a MEM match gives 10, a WB match gives 11, else 00.
- src2: any EXE match raises a stall (no EXE path for src2). Otherwise a MEM match gives 10, a WB match gives 11, else 00.
- During a stall, forward selects still reflect the current match.
- A load-use stall lasts exactly 1 cycle; the next cycle resolves through MEM (10).
- Divider FSM:
  - IDLE: on EXE_div_issue, go to BUSY with div_cnt=DIV_LAT-1.
  - BUSY: div_cnt decrements by 1 each cycle. When div_cnt==1, go to DONE on the next edge (div_cnt becomes 0).
  - DONE: hilo_div_we=1 for this one cycle. Go to IDLE, or to BUSY with a reload if EXE_div_issue is asserted in this same cycle.
- div_busy=1 in BUSY and DONE. ID_stall=1 whenever div_busy=1 and ID_hilo_use=1, so a HI/LO reader in decode issues the cycle after DONE.
- ID_stall is the OR of the load-use/EXE-conflict term and the divider lock-out term.
- EXE_div_issue in BUSY cannot occur (the lock-out prevents it). If it does occur, it is ignored and the counter is not reloaded.
- Reset asserted mid-divide aborts the operation: no hilo_div_we pulse is produced.
- div_cnt is 5 bits wide, so DIV_LAT is capped at 31.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: stall_ld_cnt increments each cycle the load-use/EXE-conflict term is 1. stall_div_cnt increments each cycle the divider lock-out term is 1. Both counters saturate at all-ones and are cleared by reset.
- When both terms are active in the same cycle, both counters increment.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load-use on src1: EXE_dest=5, EXE_memtoreg=1, ID_src1=5 → ID_stall=1 for one cycle. Next cycle MEM_dest=5, EXE_dest=0 → ID_stall=0, ID_vsrc1_for=10.
- Priority and src2: EXE_dest=MEM_dest=WB_dest=7 (EXE not a load), ID_src1=ID_src2=7 → ID_vsrc1_for=01, ID_stall=1 (src2 EXE conflict). With EXE_dest=0 → ID_vsrc2_for=10. With WB match only → 11.
- Zero register: all dests=0, ID_src1=ID_src2=0 → ID_stall=0, both selects=00.
- Divide lock-out, DIV_LAT=8: pulse EXE_div_issue at cycle 0, hold ID_hilo_use=1 → ID_stall=1 for cycles 1..8, hilo_div_we=1 at cycle 8, ID_stall=0 at cycle 9.
- Back-to-back divide: EXE_div_issue asserted in the DONE cycle → hilo_div_we pulse, div_busy stays 1, div_cnt=7 the next cycle. Reset asserted at div_cnt=3 → immediate IDLE, no hilo_div_we.
- With STALL_PERF_CNT_EN: the divide lock-out scenario above followed by one load-use stall → stall_div_cnt=8, stall_ld_cnt=1.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard control: operand forwarding selects, load-use/EXE stall,
// and a multi-cycle divider sequencer that locks HI/LO users out of decode.
// Optional stall counters are built only when STALL_PERF_CNT_EN is defined.
module id_hazard_ctrl #(
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       ID_src1,
    input  logic [4:0]       ID_src2,
    input  logic             ID_hilo_use,
    input  logic [4:0]       EXE_dest,
    input  logic             EXE_memtoreg,
    input  logic [4:0]       MEM_dest,
    input  logic [4:0]       WB_dest,
    input  logic             EXE_div_issue,
    output logic             ID_stall,
    output logic [1:0]       ID_vsrc1_for,
    output logic [1:0]       ID_vsrc2_for,
    output logic             div_busy,
    output logic [4:0]       div_cnt,
    output logic             hilo_div_we,
    output logic [CNT_W-1:0] stall_ld_cnt,
    output logic [CNT_W-1:0] stall_div_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    localparam logic [4:0] DIV_RELOAD = 5'(DIV_LAT - 1);

    div_state_t state;

    logic src1_exe, src1_mem, src1_wb;
    logic src2_exe, src2_mem, src2_wb;
    logic ld_term, div_term;

    assign src1_exe = (ID_src1 != 5'd0) && (ID_src1 == EXE_dest);
    assign src1_mem = (ID_src1 != 5'd0) && (ID_src1 == MEM_dest);
    assign src1_wb  = (ID_src1 != 5'd0) && (ID_src1 == WB_dest);
    assign src2_exe = (ID_src2 != 5'd0) && (ID_src2 == EXE_dest);
    assign src2_mem = (ID_src2 != 5'd0) && (ID_src2 == MEM_dest);
    assign src2_wb  = (ID_src2 != 5'd0) && (ID_src2 == WB_dest);

    // src2 has no EXE bypass path, so any EXE match on it must stall
    assign ld_term  = (src1_exe && EXE_memtoreg) || src2_exe;
    assign div_term = div_busy && ID_hilo_use;
    assign ID_stall = ld_term || div_term;

    always_comb begin
        ID_vsrc1_for = 2'b00;
        if (src1_exe && !EXE_memtoreg) ID_vsrc1_for = 2'b01;
        else if (src1_mem)             ID_vsrc1_for = 2'b10;
        else if (src1_wb)              ID_vsrc1_for = 2'b11;
    end

    always_comb begin
        ID_vsrc2_for = 2'b00;
        if (src2_mem)     ID_vsrc2_for = 2'b10;
        else if (src2_wb) ID_vsrc2_for = 2'b11;
    end

    assign div_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            hilo_div_we <= 1'b0;
        end else begin
            hilo_div_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (EXE_div_issue) begin
                        state   <= S_BUSY;
                        div_cnt <= DIV_RELOAD;
                    end
                end
                S_BUSY: begin
                    if (div_cnt == 5'd1) begin
                        state       <= S_DONE;
                        div_cnt     <= '0;
                        hilo_div_we <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    if (EXE_div_issue) begin
                        state   <= S_BUSY;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    div_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_ld_cnt  <= '0;
            stall_div_cnt <= '0;
        end else begin
            if (ld_term && (stall_ld_cnt != '1))
                stall_ld_cnt <= stall_ld_cnt + 1'b1;
            if (div_term && (stall_div_cnt != '1))
                stall_div_cnt <= stall_div_cnt + 1'b1;
        end
    end
`else
    assign stall_ld_cnt  = '0;
    assign stall_div_cnt = '0;
`endif

endmodule
